// File: rtl/ltl_report_collector.sv
// ltl_report_collector
// Collects non-zero automaton report vectors, tags each one with the index of
// the symbol that produced it, and buffers the records in a first-word-fall-
// through FIFO. A full FIFO drops the record and accounts for the loss with a
// sticky overflow flag and a saturating drop counter.
module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int OFS_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   run,
  input  logic [NUM_REPORTS-1:0] report_in,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [NUM_REPORTS-1:0] rpt_vec,
  output logic [OFS_W-1:0]       rpt_offset,
  output logic                   busy,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]        PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [OFS_W-1:0]   OFS_ONE = {{(OFS_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t                 r_state;
  logic [OFS_W-1:0]       r_sym_cnt;
  logic [OFS_W-1:0]       r_ofs_d;
  logic                   r_run_d;
  logic                   r_overflow;
  logic [15:0]            r_drop_cnt;
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  logic [NUM_REPORTS-1:0] r_mem_vec [FIFO_DEPTH];
  logic [OFS_W-1:0]       r_mem_ofs [FIFO_DEPTH];

  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_rec_valid;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_run_acc;
  logic [AW:0]            w_wr_ptr_nxt;
  logic [AW:0]            w_rd_ptr_nxt;
  logic                   w_next_empty;

  // FIFO status, push/pop/drop decisions and next pointer values
  always_comb begin
    w_empty     = (r_wr_ptr == r_rd_ptr);
    w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                  (r_wr_ptr[AW] != r_rd_ptr[AW]);
    w_pop       = !w_empty && rpt_ready;
    w_rec_valid = r_run_d && (report_in != {NUM_REPORTS{1'b0}});
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_push      = w_rec_valid && (!w_full || w_pop);
    w_drop      = w_rec_valid && !w_push;
    w_run_acc   = (r_state == ST_COLLECT) && run;
    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    w_next_empty = (w_wr_ptr_nxt == w_rd_ptr_nxt);
  end

  // Stream control FSM, symbol counter, run pipeline stage and drop accounting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sym_cnt  <= {OFS_W{1'b0}};
      r_ofs_d    <= {OFS_W{1'b0}};
      r_run_d    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 16'h0000;
    end else begin
      r_run_d <= w_run_acc;
      if (w_run_acc) begin
        r_ofs_d   <= r_sym_cnt;
        r_sym_cnt <= r_sym_cnt + OFS_ONE;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_COLLECT;
            r_sym_cnt <= {OFS_W{1'b0}};
          end
        end
        ST_COLLECT: begin
          if (stop) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave once nothing remains buffered after this edge.
          if (w_next_empty) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if ((r_state == ST_IDLE) && start) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= 16'h0000;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'h0001;
        end
      end
    end
  end

  // FIFO read/write pointers, one extra bit separates full from empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // FIFO storage write; contents are qualified by the pointers, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_vec[r_wr_ptr[AW-1:0]] <= report_in;
      r_mem_ofs[r_wr_ptr[AW-1:0]] <= r_ofs_d;
    end
  end

  // Output view: head entry when valid, zeros when the FIFO is empty
  always_comb begin
    rpt_valid = !w_empty;
    if (w_empty) begin
      rpt_vec    = {NUM_REPORTS{1'b0}};
      rpt_offset = {OFS_W{1'b0}};
    end else begin
      rpt_vec    = r_mem_vec[r_rd_ptr[AW-1:0]];
      rpt_offset = r_mem_ofs[r_rd_ptr[AW-1:0]];
    end
    busy     = (r_state != ST_IDLE);
    overflow = r_overflow;
    drop_cnt = r_drop_cnt;
  end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Directed testbench for ltl_report_collector: a default build and an
// OFS_W=4 build share the same stimulus; expected values are hand-derived.
module tb_ltl_report_collector;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        run;
  logic [3:0]  report_in;
  logic        rpt_ready;

  logic        rpt_valid;
  logic [3:0]  rpt_vec;
  logic [31:0] rpt_offset;
  logic        busy;
  logic        overflow;
  logic [15:0] drop_cnt;

  logic        rpt_valid4;
  logic [3:0]  rpt_vec4;
  logic [3:0]  rpt_offset4;
  logic        busy4;
  logic        overflow4;
  logic [15:0] drop_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  ltl_report_collector #(.NUM_REPORTS(4), .FIFO_DEPTH(8), .OFS_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .run(run),
    .report_in(report_in), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_vec(rpt_vec), .rpt_offset(rpt_offset), .busy(busy),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  ltl_report_collector #(.NUM_REPORTS(4), .FIFO_DEPTH(8), .OFS_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .run(run),
    .report_in(report_in), .rpt_valid(rpt_valid4), .rpt_ready(rpt_ready),
    .rpt_vec(rpt_vec4), .rpt_offset(rpt_offset4), .busy(busy4),
    .overflow(overflow4), .drop_cnt(drop_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; run = 1'b0;
    report_in = 4'b0000; rpt_ready = 1'b0;
    step(); step();

    // Reset state
    check("rst_valid", rpt_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_drop", drop_cnt, 16'd0);
    check("rst_vec", rpt_vec, 4'd0);
    check("rst_ofs", rpt_offset, 32'd0);

    // Basic: one report after the 3rd run, visible 2 cycles after that run
    rst_n = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    check("basic_busy", busy, 1'b1);
    run = 1'b1;
    step(); step(); step();               // runs with offsets 0,1,2
    report_in = 4'b0010;
    step();                               // run offset 3, report for offset 2
    report_in = 4'b0000;
    check("basic_lat2", rpt_valid, 1'b1);
    check("basic_vec", rpt_vec, 4'b0010);
    check("basic_ofs", rpt_offset, 32'd2);
    step();                               // run offset 4
    run = 1'b0;
    step();
    check("basic_hold_ofs", rpt_offset, 32'd2);
    rpt_ready = 1'b1; step(); rpt_ready = 1'b0;
    check("basic_popped", rpt_valid, 1'b0);
    stop = 1'b1; step(); stop = 1'b0;
    step();
    check("basic_idle", busy, 1'b0);

    // Run while idle must not create records
    run = 1'b1; report_in = 4'b1111;
    step(); step(); step();
    run = 1'b0; report_in = 4'b0000;
    check("idle_run_ignored", rpt_valid, 1'b0);

    // Backpressure and overflow: 10 reports into an 8-deep FIFO
    start = 1'b1; step(); start = 1'b0;
    report_in = 4'b1001; run = 1'b1;
    for (int i = 0; i < 10; i++) step();
    run = 1'b0;
    step();                               // record for offset 9
    report_in = 4'b0000;
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drop", drop_cnt, 16'd2);
    check("ovf_head", rpt_offset, 32'd0);
    step();
    check("ovf_hold", rpt_offset, 32'd0);
    check("ovf_vec", rpt_vec, 4'b1001);
    rpt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain", rpt_offset, 64'(i));
      step();
    end
    check("ovf_empty", rpt_valid, 1'b0);
    rpt_ready = 1'b0;

    // Full FIFO with simultaneous pop: offsets 10..17 fill, 18 arrives on pop
    report_in = 4'b0100; run = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("full_head", rpt_offset, 32'd10);
    run = 1'b0; rpt_ready = 1'b1;
    step();                               // pop 10, push 18
    report_in = 4'b0000;
    check("full_drop_same", drop_cnt, 16'd2);
    for (int i = 0; i < 8; i++) begin
      check("full_drain", rpt_offset, 64'(11 + i));
      step();
    end
    check("full_empty", rpt_valid, 1'b0);
    rpt_ready = 1'b0;

    // Stop and drain: report for offset 19 arrives in the stop cycle
    run = 1'b1; step(); run = 1'b0;
    stop = 1'b1; report_in = 4'b0010;
    step();
    stop = 1'b0; report_in = 4'b0000;
    check("drain_busy", busy, 1'b1);
    check("drain_ofs", rpt_offset, 32'd19);
    rpt_ready = 1'b1; step(); rpt_ready = 1'b0;
    check("drain_idle", busy, 1'b0);
    check("drain_empty", rpt_valid, 1'b0);

    // Reset mid-stream with three records buffered
    start = 1'b1; step(); start = 1'b0;
    check("start_clr_ovf", overflow, 1'b0);
    check("start_clr_drop", drop_cnt, 16'd0);
    report_in = 4'b0001; run = 1'b1;
    step(); step(); step();
    run = 1'b0; step();
    report_in = 4'b0000;
    check("mid_buffered", rpt_offset, 32'd0);
    rst_n = 1'b0; start = 1'b1; run = 1'b1; rpt_ready = 1'b1; report_in = 4'b0001;
    step();
    check("mid_rst_valid", rpt_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    rst_n = 1'b1; start = 1'b0; run = 1'b0; rpt_ready = 1'b0; report_in = 4'b0000;
    step();
    check("mid_rst_stays_empty", rpt_valid, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    run = 1'b1; step(); run = 1'b0;
    report_in = 4'b1000; step(); report_in = 4'b0000;
    check("mid_new_ofs", rpt_offset, 32'd0);
    check("mid_new_vec", rpt_vec, 4'b1000);
    rpt_ready = 1'b1; step(); rpt_ready = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    step();

    // Wrap: 4-bit counter reports offsets 15 then 0 (32-bit build: 15, 16)
    start = 1'b1; step(); start = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 16; i++) step();  // offsets 0..15
    report_in = 4'b0011;
    step();                               // run offset 16 (0 wrapped), record 15
    run = 1'b0;
    step();                               // record for the wrapped symbol
    report_in = 4'b0000;
    check("wrap4_first", rpt_offset4, 4'd15);
    check("wrap32_first", rpt_offset, 32'd15);
    rpt_ready = 1'b1; step();
    check("wrap4_second", rpt_offset4, 4'd0);
    check("wrap32_second", rpt_offset, 32'd16);
    step(); rpt_ready = 1'b0;
    check("wrap_empty", rpt_valid4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
